// File: rtl/dg0041_pkg.sv
// rtl/dg0041_pkg.sv - shared mode codes, cell select type and count-width helper
package dg0041_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_REPL = 2'b01;
    localparam logic [1:0] MODE_PUSH = 2'b10;
    localparam logic [1:0] MODE_POP  = 2'b11;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_UPPER = 2'b10,
        SEL_LOWER = 2'b11
    } cell_sel_t;

    function automatic int dg0041_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dg0041_stack_cell.sv
// rtl/dg0041_stack_cell.sv - one stack entry with hold/load/upper/lower next-value mux
module dg0041_stack_cell
    import dg0041_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  cell_sel_t        sel,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] entry_d;
    logic [WIDTH-1:0] entry_q;

    always_comb begin
        entry_d = entry_q;
        case (sel)
            SEL_HOLD:  entry_d = entry_q;
            SEL_LOAD:  entry_d = pc;
            SEL_UPPER: entry_d = upper;
            SEL_LOWER: entry_d = lower;
            default:   entry_d = entry_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/dg0041_return_stack.sv
// rtl/dg0041_return_stack.sv - parametrised return-address stack with count, full/empty and sticky error flags
module dg0041_return_stack
    import dg0041_pkg::*;
#(
    parameter int  WIDTH = 10,
    parameter int  DEPTH = 5,
    localparam int CNT_W = dg0041_cnt_w(DEPTH)
) (
    input  logic             STK_CLK,
    input  logic             STK_RST,
    input  logic             MODE1,
    input  logic             MODE0,
    input  logic             CLR_ERR,
    input  logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] SP,
    output logic [CNT_W-1:0] DEPTH_CNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVF,
    output logic             UNF
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [1:0]       mode;
    logic [WIDTH-1:0] entry [DEPTH];

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;
    logic             unf_d, unf_q;
    logic             full_w, empty_w;

    assign mode = {MODE1, MODE0};

    // Cell 0 sees PC as its "upper" neighbour; the bottom cell sees itself as "lower",
    // which gives the duplicate-down behaviour on pop.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [WIDTH-1:0] upper_w;
        logic [WIDTH-1:0] lower_w;
        cell_sel_t        sel_w;

        if (i == 0) begin : g_top
            assign upper_w = PC;
        end else begin : g_mid_up
            assign upper_w = entry[i-1];
        end

        if (i == DEPTH - 1) begin : g_bot
            assign lower_w = entry[i];
        end else begin : g_mid_lo
            assign lower_w = entry[i+1];
        end

        always_comb begin
            sel_w = SEL_HOLD;
            case (mode)
                MODE_HOLD: sel_w = SEL_HOLD;
                MODE_REPL: sel_w = (i == 0) ? SEL_LOAD : SEL_HOLD;
                MODE_PUSH: sel_w = SEL_UPPER;
                MODE_POP:  sel_w = SEL_LOWER;
                default:   sel_w = SEL_HOLD;
            endcase
        end

        dg0041_stack_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk   (STK_CLK),
            .rst   (STK_RST),
            .sel   (sel_w),
            .pc    (PC),
            .upper (upper_w),
            .lower (lower_w),
            .q     (entry[i])
        );
    end

    assign full_w  = (cnt_q == CNT_MAX);
    assign empty_w = (cnt_q == '0);

    // Clear first so that a same-edge overflow/underflow overrides CLR_ERR.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = CLR_ERR ? 1'b0 : ovf_q;
        unf_d = CLR_ERR ? 1'b0 : unf_q;
        case (mode)
            MODE_REPL: begin
                if (empty_w) cnt_d = CNT_W'(1);
            end
            MODE_PUSH: begin
                if (full_w) ovf_d = 1'b1;
                else        cnt_d = cnt_q + 1'b1;
            end
            MODE_POP: begin
                if (empty_w) unf_d = 1'b1;
                else         cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge STK_CLK or posedge STK_RST) begin
        if (STK_RST) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign SP        = entry[0];
    assign DEPTH_CNT = cnt_q;
    assign FULL      = full_w;
    assign EMPTY     = empty_w;
    assign OVF       = ovf_q;
    assign UNF       = unf_q;

endmodule
